apb_master_bridge_mc: RTL and testbench
=======================================

Name: apb_master_bridge_mc

Overview:
Parametrised APB4 master bridge. It accepts single read/write requests from the bridge-side request port and drives a shared APB bus with one pselx line per slave. Over the previous single-slave master it adds:
- address decode to NUM_SLAVES slaves
- byte strobes
- back-to-back transfers with no idle cycle
- a wait-state timeout that aborts hung slaves and reports an error.

Parameters:
ADDR_WIDTH, 32, width of addr_i/paddr
DATA_WIDTH, 32, width of data buses (multiple of 8)
NUM_SLAVES, 4, number of APB slaves (1..16)
SEL_LSB, 12, LSB of slave-index field; idx = addr[SEL_LSB +: IDX_W], IDX_W = max(1, clog2(NUM_SLAVES))
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  input  1  APB clock, all logic on rising edge
preset  input  1  asynchronous active-high reset
trans_i  input  1  bridge request valid
ready_o  output  1  bridge may present request; accepted when trans_i && ready_o
addr_i  input  ADDR_WIDTH  request address
wdata_i  input  DATA_WIDTH  write data
strb_i  input  DATA_WIDTH/8  write byte strobes
wr_rd_i  input  1  1=write, 0=read
done_o  output  1  one-cycle completion pulse
rdata_o  output  DATA_WIDTH  read data, valid with done_o
trans_err_o  output  1  error flag, valid with done_o
pselx  output  NUM_SLAVES  one-hot slave select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
pstrb  output  DATA_WIDTH/8  APB strobes; 0 on reads
prdata  input  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
pready  input  NUM_SLAVES  per-slave ready
pslverr  input  NUM_SLAVES  per-slave error

Behaviour:
- Reset state:
  - preset asserted: state=IDLE; pselx, penable, pwrite, paddr, pwdata, pstrb, done_o, rdata_o, trans_err_o = 0; timeout counter = 0; ready_o = 0.
  - Reset mid-transfer aborts immediately with no done_o.
- Registered APB/bridge outputs. ready_o is combinational: 1 in IDLE, and 1 in ACCESS in the cycle the transfer completes (pready[idx]=1). 0 otherwise and during reset.
- Acceptance: on accept, addr/wdata/strb/wr_rd are captured and idx is decoded.
  - idx < NUM_SLAVES: next state SETUP.
  - idx >= NUM_SLAVES: next state DERR.
- FSM states IDLE, SETUP, ACCESS, DERR:
  - IDLE: all pselx=0, penable=0. On accept -> SETUP or DERR.
  - SETUP (1 cycle): pselx[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb driven from captured request. pstrb = strb_i on write, 0 on read. -> ACCESS.
  - ACCESS: pselx[idx]=1, penable=1, bus signals held stable.
    - If pready[idx]=1: transfer completes.
      - Next cycle: done_o=1; trans_err_o=pslverr[idx]; rdata_o = prdata slice idx on a read without error, else 0.
      - If trans_i also accepted this cycle: -> SETUP/DERR with the new request (back-to-back); otherwise -> IDLE.
    - If pready[idx]=0: the timeout counter increments. When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES:
      - abort: pselx/penable dropped next cycle;
      - done_o=1, trans_err_o=1, rdata_o=0;
      - -> IDLE, with no acceptance that cycle.
  - DERR (1 cycle): no APB activity. done_o=1, trans_err_o=1, rdata_o=0 the next cycle. -> IDLE.
- Timing:
  - Minimum latency accept -> done_o = 3 cycles (accept, SETUP, ACCESS, done).
  - Each wait state adds 1 cycle.
- Counter and output hold rules:
  - Timeout counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1).
  - done_o lasts exactly one cycle.
  - rdata_o and trans_err_o hold their last values until the next done_o.
- Input masking: pready/pslverr/prdata of unselected slaves are ignored. pready[idx] in IDLE or SETUP is ignored.
- pselx is never multi-hot. penable=1 only while some pselx bit is 1.

Test Plan:
- Write, NUM_SLAVES=4, SEL_LSB=12: addr_i=0x0000_2010, wdata=0xA5A5_1234, strb=0xF, slave2 pready=1 -> pselx=4'b0100 in SETUP; penable next cycle; done_o 3 cycles after accept; trans_err_o=0.
- Read from slave1 with 2 wait states, prdata slice1=0xDEAD_BEEF -> pstrb=0; done_o at cycle 5 after accept; rdata_o=0xDEAD_BEEF.
- Back-to-back: trans_i held with write to 0x1000 then read from 0x3000 -> second SETUP immediately follows first ACCESS completion, no IDLE cycle; two done_o pulses 2 cycles apart.
- Slave error and decode miss:
  - pslverr[0]=1 with pready -> trans_err_o=1, rdata_o=0.
  - NUM_SLAVES=3, addr_i=0x3000 -> no pselx, done_o 2 cycles after accept, trans_err_o=1.
- Timeout: TIMEOUT_CYCLES=16, slave never readies -> abort after 16 ACCESS cycles; pselx/penable=0; done_o with trans_err_o=1. TIMEOUT_CYCLES=0 with pready after 40 cycles -> normal completion.
- Reset: assert preset in ACCESS -> all outputs 0 asynchronously, no done_o. After release, ready_o=1 and the next transfer completes normally.

Source files
------------

// File: rtl/apb_master_bridge_mc.sv
// APB4 master bridge: single request port in, shared APB bus out with one
// select line per slave. Adds address decode, byte strobes, back-to-back
// transfers and an ACCESS wait-state timeout that aborts hung slaves.
module apb_master_bridge_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               pclk,
  input  logic                               preset,
  // bridge-side request port
  input  logic                               trans_i,
  output logic                               ready_o,
  input  logic [ADDR_WIDTH-1:0]              addr_i,
  input  logic [DATA_WIDTH-1:0]              wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            strb_i,
  input  logic                               wr_rd_i,
  output logic                               done_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic                               trans_err_o,
  // APB bus
  output logic [NUM_SLAVES-1:0]              pselx,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDR_WIDTH-1:0]              paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   prdata,
  input  logic [NUM_SLAVES-1:0]              pready,
  input  logic [NUM_SLAVES-1:0]              pslverr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        cur_idx;
  logic [CNT_W-1:0]        wait_cnt;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_in_range;
  logic [NUM_SLAVES-1:0]   req_sel;

  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  logic                    accept;
  logic                    timeout_hit;

  // Decode the slave index of the request currently presented
  always_comb begin
    req_idx      = addr_i[SEL_LSB +: IDX_W];
    req_in_range = (int'(req_idx) < NUM_SLAVES);
    req_sel      = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (req_idx == IDX_W'(k)) req_sel[k] = 1'b1;
    end
  end

  // Pick the response of the selected slave only; others are ignored
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (cur_idx == IDX_W'(k)) begin
        sel_ready = pready[k];
        sel_err   = pslverr[k];
        sel_rdata = prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request handshake and wait-state limit
  always_comb begin
    ready_o     = !preset && ((state == IDLE) || ((state == ACCESS) && sel_ready));
    accept      = trans_i && ready_o;
    timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(wait_cnt) + 1) == TIMEOUT_CYCLES);
  end

  // Transfer FSM with registered APB and bridge outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      cur_idx     <= '0;
      wait_cnt    <= '0;
      pselx       <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      done_o      <= 1'b0;
      rdata_o     <= '0;
      trans_err_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            done_o      <= 1'b1;
            trans_err_o <= sel_err;
            rdata_o     <= (!pwrite && !sel_err) ? sel_rdata : '0;
            pselx       <= '0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            done_o      <= 1'b1;
            trans_err_o <= 1'b1;
            rdata_o     <= '0;
            pselx       <= '0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DERR: begin
          done_o      <= 1'b1;
          trans_err_o <= 1'b1;
          rdata_o     <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Acceptance happens from IDLE or from a completing ACCESS; placing it
      // after the case lets a new request override the return to IDLE, which
      // gives back-to-back transfers without an idle cycle.
      if (accept) begin
        cur_idx  <= req_idx;
        wait_cnt <= '0;
        paddr    <= addr_i;
        pwrite   <= wr_rd_i;
        pwdata   <= wdata_i;
        pstrb    <= wr_rd_i ? strb_i : '0;
        penable  <= 1'b0;
        if (req_in_range) begin
          pselx <= req_sel;
          state <= SETUP;
        end else begin
          pselx <= '0;
          state <= DERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge_mc.sv
// Directed bench for apb_master_bridge_mc: a 4-slave instance with a
// 16-cycle timeout and a 3-slave instance with the timeout disabled.
module tb_apb_master_bridge_mc;

  logic pclk = 1'b0;
  logic preset;

  always #5 pclk = ~pclk;

  // instance A: 4 slaves, timeout 16
  logic         trans_a, wr_a, ready_a, done_a, err_a, pen_a, pwr_a;
  logic [31:0]  addr_a, wdata_a, rdata_a, paddr_a, pwdata_a;
  logic [3:0]   strb_a, pstrb_a, psel_a, pready_a, pslverr_a;
  logic [127:0] prdata_a;

  // instance B: 3 slaves, timeout disabled
  logic         trans_b, wr_b, ready_b, done_b, err_b, pen_b, pwr_b;
  logic [31:0]  addr_b, wdata_b, rdata_b, paddr_b, pwdata_b;
  logic [3:0]   strb_b, pstrb_b;
  logic [2:0]   psel_b, pready_b, pslverr_b;
  logic [95:0]  prdata_b;

  int checks = 0;
  int errors = 0;
  logic seen_done;

  apb_master_bridge_mc #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .pclk(pclk), .preset(preset),
    .trans_i(trans_a), .ready_o(ready_a), .addr_i(addr_a), .wdata_i(wdata_a),
    .strb_i(strb_a), .wr_rd_i(wr_a), .done_o(done_a), .rdata_o(rdata_a),
    .trans_err_o(err_a), .pselx(psel_a), .penable(pen_a), .pwrite(pwr_a),
    .paddr(paddr_a), .pwdata(pwdata_a), .pstrb(pstrb_a), .prdata(prdata_a),
    .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_master_bridge_mc #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(12), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .pclk(pclk), .preset(preset),
    .trans_i(trans_b), .ready_o(ready_b), .addr_i(addr_b), .wdata_i(wdata_b),
    .strb_i(strb_b), .wr_rd_i(wr_b), .done_o(done_b), .rdata_o(rdata_b),
    .trans_err_o(err_b), .pselx(psel_b), .penable(pen_b), .pwrite(pwr_b),
    .paddr(paddr_b), .pwdata(pwdata_b), .pstrb(pstrb_b), .prdata(prdata_b),
    .pready(pready_b), .pslverr(pslverr_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    preset   = 1'b1;
    trans_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0; strb_a = '0;
    prdata_a = '0; pready_a = '0; pslverr_a = '0;
    trans_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0; strb_b = '0;
    prdata_b = '0; pready_b = '0; pslverr_b = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_ready", ready_a, 1'b0);
    check("rst_psel", psel_a, 4'b0000);
    check("rst_done", done_a, 1'b0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_err", err_a, 1'b0);
    check("rst_paddr", paddr_a, 32'h0);
    preset = 1'b0;
    #1;
    check("idle_ready", ready_a, 1'b1);

    // ---- write to slave 2, zero wait states ----
    pready_a = 4'b0100;
    trans_a = 1; wr_a = 1; addr_a = 32'h0000_2010; wdata_a = 32'hA5A5_1234; strb_a = 4'hF;
    tick();                                   // accept -> SETUP
    trans_a = 0;
    #1;
    check("wr_setup_psel", psel_a, 4'b0100);
    check("wr_setup_pen", pen_a, 1'b0);
    check("wr_setup_paddr", paddr_a, 32'h0000_2010);
    check("wr_setup_pwrite", pwr_a, 1'b1);
    check("wr_setup_pwdata", pwdata_a, 32'hA5A5_1234);
    check("wr_setup_pstrb", pstrb_a, 4'hF);
    check("wr_setup_ready_masked", ready_a, 1'b0);
    tick();                                   // ACCESS
    check("wr_access_pen", pen_a, 1'b1);
    check("wr_access_psel", psel_a, 4'b0100);
    check("wr_access_done", done_a, 1'b0);
    check("wr_access_ready", ready_a, 1'b1);
    tick();                                   // completion, 3 cycles after accept
    check("wr_done", done_a, 1'b1);
    check("wr_err", err_a, 1'b0);
    check("wr_rdata", rdata_a, 32'h0);
    check("wr_done_psel", psel_a, 4'b0000);
    check("wr_done_pen", pen_a, 1'b0);
    tick();
    check("wr_done_pulse", done_a, 1'b0);

    // ---- read from slave 1 with two wait states ----
    pready_a = 4'b0000;
    pslverr_a = 4'b0100;                      // unselected slave error ignored
    prdata_a[32 +: 32] = 32'hDEAD_BEEF;
    prdata_a[64 +: 32] = 32'h1111_1111;
    trans_a = 1; wr_a = 0; addr_a = 32'h0000_1004; strb_a = 4'hF;
    tick();                                   // cycle 1: SETUP
    trans_a = 0;
    check("rd_setup_psel", psel_a, 4'b0010);
    check("rd_setup_pstrb", pstrb_a, 4'h0);
    check("rd_setup_pwrite", pwr_a, 1'b0);
    tick();                                   // cycle 2: ACCESS wait
    check("rd_wait1_done", done_a, 1'b0);
    tick();                                   // cycle 3: ACCESS wait
    check("rd_wait2_done", done_a, 1'b0);
    check("rd_wait2_pen", pen_a, 1'b1);
    tick();                                   // cycle 4: ACCESS, slave ready
    pready_a = 4'b0010;
    #1;
    check("rd_access_ready", ready_a, 1'b1);
    tick();                                   // cycle 5: done
    pready_a = 4'b0000;
    check("rd_done", done_a, 1'b1);
    check("rd_rdata", rdata_a, 32'hDEAD_BEEF);
    check("rd_err", err_a, 1'b0);
    pslverr_a = 4'b0000;

    // ---- back-to-back write slave 1, read slave 3 ----
    tick();
    pready_a = 4'b1111;
    prdata_a[96 +: 32] = 32'h3333_CAFE;
    trans_a = 1; wr_a = 1; addr_a = 32'h0000_1000; wdata_a = 32'h1234_5678; strb_a = 4'h3;
    tick();                                   // SETUP of first
    wr_a = 0; addr_a = 32'h0000_3000;
    check("b2b_setup1_psel", psel_a, 4'b0010);
    check("b2b_setup1_pstrb", pstrb_a, 4'h3);
    tick();                                   // ACCESS of first, second accepted here
    check("b2b_access1_pen", pen_a, 1'b1);
    tick();                                   // first done, second SETUP
    trans_a = 0;
    check("b2b_done1", done_a, 1'b1);
    check("b2b_done1_rdata", rdata_a, 32'h0);
    check("b2b_setup2_psel", psel_a, 4'b1000);
    check("b2b_setup2_pen", pen_a, 1'b0);
    check("b2b_setup2_paddr", paddr_a, 32'h0000_3000);
    check("b2b_setup2_pstrb", pstrb_a, 4'h0);
    tick();                                   // second ACCESS
    check("b2b_gap_done", done_a, 1'b0);
    tick();                                   // second done, 2 cycles after first
    check("b2b_done2", done_a, 1'b1);
    check("b2b_rdata2", rdata_a, 32'h3333_CAFE);

    // ---- slave error on slave 0 ----
    pready_a = 4'b0001; pslverr_a = 4'b0001;
    prdata_a[0 +: 32] = 32'h5555_AAAA;
    trans_a = 1; wr_a = 0; addr_a = 32'h0000_0008;
    tick();
    trans_a = 0;
    tick();
    tick();
    check("serr_done", done_a, 1'b1);
    check("serr_err", err_a, 1'b1);
    check("serr_rdata", rdata_a, 32'h0);
    tick();
    check("serr_err_hold", err_a, 1'b1);
    check("serr_done_pulse", done_a, 1'b0);
    pslverr_a = 4'b0000;

    // ---- timeout on slave 2 ----
    pready_a = 4'b0000;
    trans_a = 1; wr_a = 1; addr_a = 32'h0000_2000; wdata_a = 32'h0; strb_a = 4'h1;
    tick();                                   // SETUP
    trans_a = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 16; i++) begin        // 16 ACCESS cycles
      tick();
      if (done_a) seen_done = 1'b1;
    end
    check("to_no_early_done", seen_done, 1'b0);
    check("to_psel_held", psel_a, 4'b0100);
    check("to_pen_held", pen_a, 1'b1);
    tick();                                   // abort
    check("to_done", done_a, 1'b1);
    check("to_err", err_a, 1'b1);
    check("to_rdata", rdata_a, 32'h0);
    check("to_psel", psel_a, 4'b0000);
    check("to_pen", pen_a, 1'b0);
    check("to_idle_ready", ready_a, 1'b1);

    // ---- asynchronous reset in ACCESS ----
    tick();
    pready_a = 4'b0000;
    trans_a = 1; wr_a = 0; addr_a = 32'h0000_0000;
    tick();                                   // SETUP
    trans_a = 0;
    tick();                                   // ACCESS
    check("rstmid_pen", pen_a, 1'b1);
    #2 preset = 1'b1;
    #1;
    check("rstmid_psel", psel_a, 4'b0000);
    check("rstmid_pen0", pen_a, 1'b0);
    check("rstmid_ready", ready_a, 1'b0);
    check("rstmid_err", err_a, 1'b0);
    check("rstmid_done", done_a, 1'b0);
    tick();
    preset = 1'b0;
    #1;
    check("rstrel_ready", ready_a, 1'b1);
    tick();
    check("rstrel_no_done", done_a, 1'b0);
    pready_a = 4'b0001;
    trans_a = 1; wr_a = 1; addr_a = 32'h0000_0004; wdata_a = 32'hCAFE_0001; strb_a = 4'hF;
    tick();
    trans_a = 0;
    check("post_rst_psel", psel_a, 4'b0001);
    tick();
    tick();
    check("post_rst_done", done_a, 1'b1);
    check("post_rst_err", err_a, 1'b0);

    // ---- decode miss on 3-slave instance ----
    trans_b = 1; wr_b = 0; addr_b = 32'h0000_3000;
    #1;
    check("dm_ready", ready_b, 1'b1);
    tick();                                   // DERR
    trans_b = 0;
    check("dm_psel", psel_b, 3'b000);
    check("dm_done_early", done_b, 1'b0);
    tick();                                   // done 2 cycles after accept
    check("dm_done", done_b, 1'b1);
    check("dm_err", err_b, 1'b1);
    check("dm_rdata", rdata_b, 32'h0);
    check("dm_pen", pen_b, 1'b0);

    // ---- timeout disabled: slave 2 readies after 40+ cycles ----
    tick();
    pready_b = 3'b000;
    prdata_b[64 +: 32] = 32'h0BAD_F00D;
    trans_b = 1; wr_b = 0; addr_b = 32'h0000_2000;
    tick();                                   // SETUP
    trans_b = 0;
    tick();                                   // first ACCESS cycle
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_b) seen_done = 1'b1;
    end
    check("nto_no_abort", seen_done, 1'b0);
    check("nto_psel_held", psel_b, 3'b100);
    pready_b = 3'b100;
    tick();
    check("nto_done", done_b, 1'b1);
    check("nto_err", err_b, 1'b0);
    check("nto_rdata", rdata_b, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
